// File: rtl/sram_mem_controller.sv
// Sequences one 32-bit pipeline load/store as two 16-bit SRAM half-word accesses
// (low half first), holding ready low until the access completes.
module sram_mem_controller #(
    parameter int          PHASE_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic [31:0] read_data_q, read_data_d;

    logic hi_phase;
    logic last_cyc;

    assign hi_phase  = (state_q == S_HI);
    assign last_cyc  = (cnt_q == LAST_CNT);
    assign read_data = read_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        word_d      = word_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        case (state_q)
            S_IDLE: begin
                // A simultaneous read+write is treated as a write.
                if (rd_en || wr_en) begin
                    op_wr_d = wr_en;
                    word_d  = 17'((address - ADDR_BASE) >> 2);
                    data_d  = write_data;
                    cnt_d   = 4'd0;
                    state_d = S_LO;
                end
            end
            S_LO, S_HI: begin
                if (last_cyc) begin
                    cnt_d   = 4'd0;
                    state_d = hi_phase ? S_DONE : S_HI;
                    if (!op_wr_q) begin
                        if (hi_phase) read_data_d[31:16] = sram_dq_in;
                        else          read_data_d[15:0]  = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM pins decode from registered state only, so addr/dq are stable for a
    // whole phase and we_n rises one cycle before they can change.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_ce_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        case (state_q)
            S_IDLE: ready = ~(rd_en | wr_en);
            S_DONE: ready = 1'b1;
            default: begin
                sram_addr = {word_q, hi_phase};
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                if (op_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = hi_phase ? data_q[31:16] : data_q[15:0];
                    sram_we_n   = last_cyc;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            word_q      <= 17'd0;
            data_q      <= 32'd0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: behavioural SRAMs, a cycle-timeline reference model
// checked every cycle, directed literal cases, then randomized traffic.
module tb_sram_mem_controller;

    localparam int P = 2;
    localparam int MEMW = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = 32'd0, write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    logic        rd4 = 1'b0, wr4 = 1'b0;
    logic [31:0] address4 = 32'd0, wdata4 = 32'd0;
    logic [31:0] read_data4;
    logic        ready4;
    logic [17:0] sram_addr4;
    logic [15:0] dq_out4, dq_in4;
    logic        dq_oe4, we_n4, oe_n4, ce_n4, ub_n4, lb_n4;

    always #5 clk = ~clk;

    sram_mem_controller #(.PHASE_CYCLES(P), .ADDR_BASE(32'd1024)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_mem_controller #(.PHASE_CYCLES(4), .ADDR_BASE(32'd1024)) u_dut4 (
        .clk(clk), .rst(rst), .rd_en(rd4), .wr_en(wr4), .address(address4),
        .write_data(wdata4), .read_data(read_data4), .ready(ready4),
        .sram_addr(sram_addr4), .sram_dq_out(dq_out4), .sram_dq_oe(dq_oe4),
        .sram_dq_in(dq_in4), .sram_we_n(we_n4), .sram_oe_n(oe_n4),
        .sram_ce_n(ce_n4), .sram_ub_n(ub_n4), .sram_lb_n(lb_n4)
    );

    // Behavioural asynchronous SRAMs: commit on we_n rising edge
    logic [15:0] mem  [0:MEMW-1];
    logic [15:0] mem4 [0:MEMW-1];
    assign sram_dq_in = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr] : 16'h0000;
    assign dq_in4     = (!oe_n4 && !ce_n4) ? mem4[sram_addr4] : 16'h0000;

    always @(posedge sram_we_n) if (sram_ce_n === 1'b0) mem[sram_addr] <= sram_dq_out;
    always @(posedge we_n4)     if (ce_n4 === 1'b0)     mem4[sram_addr4] <= dq_out4;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: m_t = cycles into the current access (0 = idle)
    int          m_t = 0;
    logic        m_wr = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [16:0] m_w = 17'd0;
    logic [31:0] exp_rd = 32'd0;
    logic [15:0] exp_mem [0:MEMW-1];

    always @(negedge clk) begin
        int k;
        logic hi;
        logic [17:0] ha;
        if (!rst) begin
            m_t    = 0;
            exp_rd = 32'd0;
            chk("rst_ready", 32'(ready), 32'(!(rd_en || wr_en)));
            chk("rst_ctl", 32'({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'h3E);
            chk("rst_addr", 32'(sram_addr), 32'd0);
            chk("rst_dq", 32'(sram_dq_out), 32'd0);
            chk("rst_rdata", read_data, 32'd0);
        end else begin
            k  = (m_t - 1) % P;
            hi = (m_t > P);
            ha = {m_w, hi};
            if (m_t == 0) begin
                chk("idle_ready", 32'(ready), 32'(!(rd_en || wr_en)));
                chk("idle_ctl", 32'({sram_we_n, sram_oe_n, sram_ce_n, sram_dq_oe}), 32'hE);
            end else if (m_t <= 2 * P) begin
                chk("busy_ready", 32'(ready), 32'd0);
                chk("busy_sel", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
                chk("busy_addr", 32'(sram_addr), 32'(ha));
                if (m_wr) begin
                    chk("wr_we_n", 32'(sram_we_n), 32'(k == P - 1));
                    chk("wr_oe", 32'({sram_oe_n, sram_dq_oe}), 32'h3);
                    chk("wr_dq", 32'(sram_dq_out), 32'(hi ? m_data[31:16] : m_data[15:0]));
                end else begin
                    chk("rd_ctl", 32'({sram_we_n, sram_oe_n, sram_dq_oe}), 32'h4);
                end
            end else begin
                chk("done_ready", 32'(ready), 32'd1);
                chk("done_ctl", 32'({sram_we_n, sram_oe_n, sram_ce_n, sram_dq_oe}), 32'hE);
                if (m_wr) begin
                    chk("mem_lo", 32'(mem[{m_w, 1'b0}]), 32'(m_data[15:0]));
                    chk("mem_hi", 32'(mem[{m_w, 1'b1}]), 32'(m_data[31:16]));
                    exp_mem[{m_w, 1'b0}] = m_data[15:0];
                    exp_mem[{m_w, 1'b1}] = m_data[31:16];
                end
            end
            chk("read_data", read_data, exp_rd);
            if (m_t >= 1 && m_t <= 2 * P && !m_wr && k == P - 1) begin
                if (hi) exp_rd[31:16] = exp_mem[ha];
                else    exp_rd[15:0]  = exp_mem[ha];
            end
            if (m_t == 0) begin
                if (rd_en || wr_en) begin
                    m_wr   = wr_en;
                    m_data = write_data;
                    m_w    = 17'((address - 32'd1024) >> 2);
                    m_t    = 1;
                end
            end else if (m_t == 2 * P + 1) m_t = 0;
            else m_t = m_t + 1;
        end
    end

    int          r_lo, r_we, r_oe, r_dqoe;
    logic [31:0] r_rd;
    logic [17:0] addr_seq [$];

    // Present a request in the next cycle and hold it until ready; inputs stay put afterwards.
    task automatic run_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit done = 0;
        @(posedge clk); #1;
        rd_en = r; wr_en = w; address = a; write_data = d;
        r_lo = 0; r_we = 0; r_oe = 0; r_dqoe = 0; r_rd = 32'd0;
        addr_seq.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sram_ce_n) addr_seq.push_back(sram_addr);
            r_we   += int'(!sram_we_n);
            r_oe   += int'(!sram_oe_n);
            r_dqoe += int'(sram_dq_oe);
            if (ready) begin
                r_rd = read_data;
                done = 1;
                break;
            end
            r_lo++;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL ready_timeout: ready stayed low for 40 cycles, expected within %0d", 2 * P + 1);
        end
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    logic        rdy4 [0:9];
    logic [31:0] rdv4 [0:9];

    initial begin
        int lows;
        for (int i = 0; i < MEMW; i++) begin
            mem[i] = 16'h0; mem4[i] = 16'h0; exp_mem[i] = 16'h0;
        end
        mem4[0] = 16'hBEEF;
        mem4[1] = 16'hCAFE;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Directed write of 0x12345678 to the base address
        run_req(1'b0, 1'b1, 32'd1024, 32'h12345678);
        chk("wr_ready_low_cycles", 32'(r_lo), 32'd5);
        chk("wr_we_low_cycles", 32'(r_we), 32'd2);
        chk("wr_word0", 32'(mem[0]), 32'h5678);
        chk("wr_word1", 32'(mem[1]), 32'h1234);
        go_idle(1);

        run_req(1'b1, 1'b0, 32'd1024, 32'h0);
        chk("rd_value", r_rd, 32'h12345678);
        chk("rd_dq_oe_cycles", 32'(r_dqoe), 32'd0);
        chk("rd_oe_low_cycles", 32'(r_oe), 32'd4);
        go_idle(1);

        run_req(1'b0, 1'b1, 32'd1028, 32'hA5A50F0F);
        chk("addr_seq_len", 32'(addr_seq.size()), 32'd4);
        if (addr_seq.size() == 4) begin
            chk("addr_lo", 32'(addr_seq[0]), 32'd2);
            chk("addr_hi", 32'(addr_seq[3]), 32'd3);
        end
        go_idle(0);

        run_req(1'b1, 1'b1, 32'd1032, 32'hDEADBEEF);
        chk("both_rdata_kept", r_rd, 32'h12345678);
        chk("both_word4", 32'(mem[4]), 32'hBEEF);
        chk("both_word5", 32'(mem[5]), 32'hDEAD);
        go_idle(1);

        // Back-to-back: write then read with no idle cycle between
        run_req(1'b0, 1'b1, 32'd1040, 32'h0BADF00D);
        run_req(1'b1, 1'b0, 32'd1040, 32'h0);
        chk("b2b_ready_low", 32'(r_lo), 32'd5);
        chk("b2b_value", r_rd, 32'h0BADF00D);
        go_idle(1);

        // Reset in the last HI cycle of a write
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1048; write_data = 32'h11112222;
        repeat (2 * P) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_ctl", 32'({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'h3E);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_rdata", read_data, 32'd0);
        chk("abort_ready_req", 32'(ready), 32'd0);
        wr_en = 1'b0;
        #1 chk("abort_ready_idle", 32'(ready), 32'd1);
        exp_mem[12] = mem[12];
        exp_mem[13] = mem[13];
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_abort_ready", 32'(ready), 32'd1);

        // P=4 read on the second instance
        @(posedge clk); #1;
        rd4 = 1'b1; address4 = 32'd1024;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            rdy4[i] = ready4;
            rdv4[i] = read_data4;
        end
        @(posedge clk); #1 rd4 = 1'b0;
        lows = 0;
        for (int i = 0; i <= 9; i++) lows += int'(!rdy4[i]);
        chk("p4_ready_low", 32'(lows), 32'd9);
        chk("p4_ready_done", 32'(rdy4[9]), 32'd1);
        chk("p4_rd_c4", rdv4[4], 32'h0);
        chk("p4_rd_c5", rdv4[5], 32'h0000BEEF);
        chk("p4_rd_c8", rdv4[8], 32'h0000BEEF);
        chk("p4_rd_c9", rdv4[9], 32'hCAFEBEEF);

        // Randomized traffic against the every-cycle model
        for (int n = 0; n < 300; n++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = 32'd1024 + 32'($urandom_range(0, 15)) * 4;
            run_req(op != 1, op != 0, a, $urandom());
            if ($urandom_range(0, 1) == 1) go_idle(int'($urandom_range(0, 2)));
        end
        go_idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Multi-cycle controller sequencing the external 16-bit SRAM on behalf of the pipeline's memory stage. Takes the memory-read/write enables, address (ALU result) and store data (Rm value) latched by the EXE-stage pipeline register. Splits each 32-bit word access into two 16-bit SRAM half-word accesses. Holds `ready` low to freeze the pipeline until the access completes.

## Interface
- `PHASE_CYCLES`, 2: cycles per half-word access; legal range 2–15.
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rd_en` in 1: memory read request (MEM_R_EN from the EXE-stage register).
- `wr_en` in 1: memory write request (MEM_W_EN).
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data (val_Rm).
- `read_data` out 32: load result, registered.
- `ready` out 1: 1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: data driven to SRAM.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_out`; the top level builds the inout.
- `sram_dq_in` in 16: data read from SRAM.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM controls.

## Operation
- **States:** IDLE, LO, HI, DONE. A 4-bit phase counter `cnt` counts 0..PHASE_CYCLES-1 inside LO and HI.
- **IDLE:**
  - `ready = ~(rd_en | wr_en)` (combinational).
  - On any request, latch the operation, `address`, `write_data`; clear `cnt`; go to LO.
  - Both `rd_en` and `wr_en` high: perform a write; the read is ignored.
- **Address mapping:** word offset `w = (address - ADDR_BASE) >> 2`, 32-bit modulo arithmetic, truncated to 17 bits.
  - LO drives `sram_addr = {w, 1'b0}`.
  - HI drives `sram_addr = {w, 1'b1}`.
  - Out-of-range addresses wrap silently; there is no error output.
- **LO / HI, write:**
  - `sram_ce_n = sram_ub_n = sram_lb_n = 0`; `sram_dq_oe = 1`.
  - `sram_dq_out` = data[15:0] in LO, data[31:16] in HI.
  - `sram_we_n = 0` for `cnt < PHASE_CYCLES-1` and 1 on the last phase cycle, giving a data-hold cycle. The SRAM commits on the `we_n` rising edge.
- **LO / HI, read:**
  - `sram_oe_n = 0`; `sram_dq_oe = 0`.
  - On the last phase cycle, sample `sram_dq_in` into `read_data[15:0]` (LO) or `read_data[31:16]` (HI).
- **Phase advance:** the last phase cycle in LO goes to HI; in HI it goes to DONE. `cnt` clears on each transition.
- **DONE:**
  - `ready = 1` for exactly one cycle; all SRAM controls are inactive.
  - Requests are ignored (they belong to the instruction now completing).
  - Always returns to IDLE.
- **read_data:** changes only during reads; writes leave it unchanged.
- **Reset values (async, `rst = 0`):**
  - State IDLE, `cnt = 0`, `read_data = 0`.
  - `sram_addr = 0`, `sram_dq_out = 0`, `sram_dq_oe = 0`.
  - All `*_n` outputs = 1.
  - `ready = ~(rd_en | wr_en)`.
- **Reset mid-access:** aborts immediately. A half-completed write may leave the SRAM partially updated; this is accepted.
- **Outside LO/HI:** all SRAM control outputs are inactive (1) and `sram_dq_oe = 0`.

## Timing
- A request is present in IDLE in cycle 0:
  - LO occupies cycles 1..P.
  - HI occupies cycles P+1..2P.
  - DONE is cycle 2P+1, with `ready = 1`.
  - P = PHASE_CYCLES.
- `ready` is low for 2P+1 cycles (cycles 0..2P). With P=2: low for 5 cycles, high in cycle 5.
- Read data is fully valid at `read_data` from DONE onward. It stays stable until the next read's LO sample.
- Back-to-back requests: the cycle after DONE is IDLE. A new request there drops `ready` again in the same cycle; there is no bubble beyond the DONE cycle.
- Data-path outputs (`sram_addr`, `sram_dq_out`) may be combinational from state plus latched registers. They must be glitch-free relative to the `we_n` rising edge: `addr` and `dq` stay constant for the whole phase.

## Test plan
- **Write:** P=2, `wr_en=1`, `address=1024`, `write_data=0x12345678`.
  - SRAM model word 0 = 0x5678, word 1 = 0x1234.
  - `ready` low cycles 0–4, high in cycle 5; `we_n` low exactly 1 cycle per phase.
- **Read-back:** `rd_en=1`, `address=1024`, SRAM words 0/1 = 0x5678/0x1234.
  - `read_data = 0x12345678` in DONE.
  - `sram_dq_oe = 0` throughout; `oe_n` low 4 cycles.
- **Addressing and priority:** `address=1028` gives `sram_addr` 2 then 3. Simultaneous `rd_en=wr_en=1` performs a write and leaves `read_data` unchanged.
- **Back-to-back:** write then read, with requests held until `ready`.
  - Exactly one DONE cycle between the two accesses.
  - Read returns the just-written value; no extra access is issued during DONE.
- **Reset mid-access:** assert `rst=0` in HI of a write.
  - Outputs immediately go to reset values, state IDLE, `read_data = 0`.
  - After release with no request, `ready = 1`.
- **Parameter:** P=4 read. `ready` low 9 cycles; sampling happens only on cycles 4 and 8 relative to request.
